// File: rtl/imem_arb_pkg.sv
// Shared constants, response type and fault rule for the instruction-fetch arbiter.
// Fault = misaligned byte address or word index beyond the end of instruction memory.
package imem_arb_pkg;

  localparam int IMEM_ADDR_W = 32;
  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_DEPTH  = 64;
  localparam int ARB_N_REQ   = 4;

  typedef struct packed {
    logic                   valid;
    logic                   err;
    logic [IMEM_DATA_W-1:0] data;
  } imem_resp_t;

  // Address is widened to 64 bits so one function serves any ADDR_W up to 64.
  function automatic logic is_fault(input logic [63:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || (addr[63:2] >= 62'(depth));
  endfunction

endpackage

// File: rtl/imem_fetch_arbiter_rr_picker.sv
// Round-robin picker: first eligible index at or after ptr, wrapping; purely combinational.
// Zero latency; an empty eligible set yields no grant and index 0.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_elig,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_cand;

  // Scan from the farthest offset down so the closest eligible index to ptr wins.
  always_comb begin
    w_cand = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = IW'((int'(i_ptr) + k) % N);
      if (i_elig[w_cand]) begin
        o_idx = w_cand;
        o_any = 1'b1;
      end
    end
  end

  always_comb begin
    o_grant = '0;
    if (o_any) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Round-robin sharing of a combinational-read instruction memory; one fetch per cycle,
// response held in a per-requester slot from the next cycle until consumed or flushed.
module imem_fetch_arbiter
  import imem_arb_pkg::*;
#(
  parameter int N_REQ     = ARB_N_REQ,
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int DATA_W    = IMEM_DATA_W,
  parameter int MEM_DEPTH = IMEM_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           resp_valid,
  output logic [N_REQ*DATA_W-1:0]    resp_data,
  output logic [N_REQ-1:0]           resp_err,
  input  logic [N_REQ-1:0]           resp_ready,
  input  logic [N_REQ-1:0]           flush,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_rd,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]  r_valid;
  logic [N_REQ-1:0]  r_err;
  logic [DATA_W-1:0] r_data [N_REQ];
  logic [IW-1:0]     r_ptr;

  logic [N_REQ-1:0]  w_free;
  logic [N_REQ-1:0]  w_elig;
  logic [N_REQ-1:0]  w_grant;
  logic [IW-1:0]     w_idx;
  logic              w_any;
  logic [ADDR_W-1:0] w_addr;
  logic              w_fault;

  // A slot is reusable this cycle if empty or being drained; reset holds every grant off.
  assign w_free = ~r_valid | resp_ready;
  assign w_elig = req_valid & w_free & ~flush & {N_REQ{rst_n}};

  rr_picker #(.N(N_REQ), .IW(IW)) u_picker (
    .i_elig  (w_elig),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) w_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign w_fault = is_fault(64'(w_addr), MEM_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_err   <= '0;
      for (int i = 0; i < N_REQ; i++) r_data[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        // Flush wins over everything; grant is already masked by it.
        if (flush[i]) begin
          r_valid[i] <= 1'b0;
          r_err[i]   <= 1'b0;
        end else if (w_grant[i]) begin
          r_valid[i] <= 1'b1;
          r_err[i]   <= w_fault;
          r_data[i]  <= w_fault ? '0 : mem_rd;
        end else if (resp_ready[i]) begin
          r_valid[i] <= 1'b0;
          r_err[i]   <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  assign req_ready  = w_grant;
  assign grant_id   = w_idx;
  assign mem_addr   = w_addr;
  assign resp_valid = r_valid;
  assign resp_err   = r_err;

  for (genvar g = 0; g < N_REQ; g++) begin : g_resp
    assign resp_data[g*DATA_W +: DATA_W] = r_data[g];
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Scoreboard bench: per-requester command queues feed a driver, expected responses
// are queued on issue and popped by an independent monitor on each consumed response.
module tb_imem_fetch_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [N*DW-1:0] resp_data;
  logic [N-1:0]    resp_err;
  logic [N-1:0]    resp_ready;
  logic [N-1:0]    flush;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_rd;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  // Memory image: word k holds 0xC0DE_0000 + k.
  assign mem_rd = {16'hC0DE, mem_addr[17:2]};

  imem_fetch_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .resp_ready (resp_ready),
    .flush      (flush),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .grant_id   (grant_id)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          err;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  cmd_t cmd_q [N][$];
  exp_t exp_q [N][$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push(input int r, input logic [AW-1:0] a, input logic e, input logic [DW-1:0] d);
    cmd_t c;
    c.addr = a;
    c.err  = e;
    c.data = d;
    cmd_q[r].push_back(c);
  endtask

  function automatic bit idle();
    bit b;
    b = (req_valid == '0);
    for (int i = 0; i < N; i++) begin
      if (cmd_q[i].size() != 0 || exp_q[i].size() != 0) b = 1'b0;
    end
    return b;
  endfunction

  task automatic tick2();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!idle() && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain complete", 64'(idle()), 64'd1);
  endtask

  // Driver: drop a request once accepted, then load that requester's next command.
  initial begin
    logic [N-1:0] acc;
    cmd_t c;
    exp_t e;
    forever begin
      @(negedge clk);
      acc = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (rst_n && !req_valid[i] && cmd_q[i].size() > 0) begin
          c = cmd_q[i].pop_front();
          req_addr[i*AW +: AW] = c.addr;
          req_valid[i] = 1'b1;
          e.err  = c.err;
          e.data = c.data;
          exp_q[i].push_back(e);
        end
      end
    end
  end

  // Monitor: every consumed or flushed response retires the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < N; i++) begin
          if (resp_valid[i] && (resp_ready[i] || flush[i])) begin
            if (exp_q[i].size() == 0) begin
              chk($sformatf("unexpected resp r%0d", i), 64'(resp_data[i*DW +: DW]), 64'hDEAD);
            end else begin
              e = exp_q[i].pop_front();
              if (!flush[i]) begin
                chk($sformatf("resp_data r%0d", i), 64'(resp_data[i*DW +: DW]), 64'(e.data));
                chk($sformatf("resp_err r%0d", i), 64'(resp_err[i]), 64'(e.err));
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_addr   = '0;
    resp_ready = '0;
    flush      = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst resp_valid", 64'(resp_valid), 64'h0);
    chk("rst resp_err", 64'(resp_err), 64'h0);
    chk("rst resp_data nonzero", 64'(resp_data != '0), 64'h0);
    chk("rst req_ready", 64'(req_ready), 64'h0);
    chk("rst mem_addr", 64'(mem_addr), 64'h0);
    chk("rst grant_id", 64'(grant_id), 64'h0);
    rst_n      = 1'b1;
    resp_ready = '1;

    // Single fetch from requester 0.
    push(0, 32'h8, 1'b0, 32'hC0DE_0002);
    @(posedge clk);
    @(negedge clk);
    chk("single req_ready", 64'(req_ready), 64'h1);
    chk("single mem_addr", 64'(mem_addr), 64'h8);
    chk("single grant_id", 64'(grant_id), 64'h0);
    @(negedge clk);
    chk("single resp_valid0", 64'(resp_valid[0]), 64'h1);
    chk("single resp_err0", 64'(resp_err[0]), 64'h0);

    // All four streaming; pointer sits at 1 after the single fetch.
    tick2();
    for (int r = 0; r < N; r++)
      for (int k = 0; k < 3; k++)
        push(r, 32'(64 * r + 4 * k), 1'b0, 32'hC0DE_0000 + 32'(16 * r + k));
    @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 12; j++) begin
      g = (1 + j) % 4;
      chk($sformatf("rr grant_id cyc%0d", j), 64'(grant_id), 64'(g));
      chk($sformatf("rr req_ready cyc%0d", j), 64'(req_ready), 64'(1 << g));
      chk($sformatf("rr mem_addr cyc%0d", j), 64'(mem_addr), 64'(64 * g + 4 * (j / 4)));
      if (j < 11) @(negedge clk);
    end

    // Requester 1 holds its response; requester 2 must keep flowing.
    tick2();
    resp_ready[1] = 1'b0;
    push(1, 32'h10, 1'b0, 32'hC0DE_0004);
    @(posedge clk);
    @(negedge clk);
    chk("bp first grant", 64'(req_ready), 64'h2);
    tick2();
    push(1, 32'h14, 1'b0, 32'hC0DE_0005);
    for (int k = 0; k < 4; k++) push(2, 32'(32'h80 + 4 * k), 1'b0, 32'hC0DE_0020 + 32'(k));
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp req_ready cyc%0d", k), 64'(req_ready), 64'h4);
      chk($sformatf("bp grant_id cyc%0d", k), 64'(grant_id), 64'h2);
      chk($sformatf("bp hold valid1 cyc%0d", k), 64'(resp_valid[1]), 64'h1);
      chk($sformatf("bp hold data1 cyc%0d", k), 64'(resp_data[DW +: DW]), 64'hC0DE_0004);
      if (k < 3) @(negedge clk);
    end
    tick2();
    resp_ready[1] = 1'b1;
    drain();

    // Fault boundaries on requester 3.
    tick2();
    push(3, 32'h6,   1'b1, 32'h0);
    push(3, 32'h100, 1'b1, 32'h0);
    push(3, 32'hFC,  1'b0, 32'hC0DE_003F);
    drain();

    // Flush with a full slot, a pending request and resp_ready all at once.
    tick2();
    resp_ready[0] = 1'b0;
    push(0, 32'h20, 1'b0, 32'hC0DE_0008);
    @(posedge clk);
    @(negedge clk);
    chk("flush setup grant", 64'(req_ready), 64'h1);
    tick2();
    push(0, 32'h24, 1'b0, 32'hC0DE_0009);
    tick2();
    flush[0]      = 1'b1;
    resp_ready[0] = 1'b1;
    @(negedge clk);
    chk("flush blocks grant", 64'(req_ready), 64'h0);
    chk("flush grant_id idle", 64'(grant_id), 64'h0);
    chk("flush slot still full", 64'(resp_valid[0]), 64'h1);
    tick2();
    flush[0] = 1'b0;
    @(negedge clk);
    chk("flush slot cleared", 64'(resp_valid[0]), 64'h0);
    chk("post-flush grant", 64'(req_ready), 64'h1);
    drain();

    // Reset pulsed while traffic is in flight.
    tick2();
    for (int r = 0; r < N; r++)
      for (int k = 0; k < 4; k++)
        push(r, 32'(64 * r + 4 * k), 1'b0, 32'hC0DE_0000 + 32'(16 * r + k));
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    tick2();
    chk("pre-reset slot busy", 64'(resp_valid != '0), 64'h1);
    rst_n     = 1'b0;
    req_valid = '0;
    for (int r = 0; r < N; r++) begin
      cmd_q[r].delete();
      exp_q[r].delete();
    end
    #1;
    chk("mid rst resp_valid", 64'(resp_valid), 64'h0);
    chk("mid rst resp_err", 64'(resp_err), 64'h0);
    chk("mid rst req_ready", 64'(req_ready), 64'h0);
    chk("mid rst grant_id", 64'(grant_id), 64'h0);
    tick2();
    rst_n = 1'b1;
    push(2, 32'h30, 1'b0, 32'hC0DE_000C);
    push(0, 32'h34, 1'b0, 32'hC0DE_000D);
    push(3, 32'h38, 1'b0, 32'hC0DE_000E);
    @(posedge clk);
    @(negedge clk);
    chk("post-rst grant_id", 64'(grant_id), 64'h0);
    chk("post-rst req_ready", 64'(req_ready), 64'h1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
